// File: rtl/trap_ctrl.sv
// Trap sequencer: exceptions, interrupts and mret -> flush -> CSR strobe -> redirect.
// Define TRAP_VECTORED_EN to enable mtvec vectored mode for interrupts.
module trap_ctrl (
  input  logic        clk,
  input  logic        nrst,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        mret_valid,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic        irq_sw,
  input  logic        irq_timer,
  input  logic        irq_ext,
  input  logic        csr_interrupt_en,
  input  logic [31:0] csr_mie,
  input  logic [1:0]  csr_mtvec_mode,
  input  logic [29:0] csr_mtvec_base,
  input  logic [31:0] csr_mepc,
  output logic        flush_req,
  input  logic        flush_ack,
  output logic        busy,
  output logic        csr_exception,
  output logic [31:0] csr_exception_cause,
  output logic [31:0] csr_exception_pc,
  output logic [31:0] mip_pend,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, FLUSH, TRAP, RET} state_t;

  state_t      state, state_nxt;
  logic        tgt_ret, tgt_ret_nxt;
  logic        is_irq, is_irq_nxt;
  logic [31:0] cause_q, cause_nxt;
  logic [31:0] epc_q, epc_nxt;
  logic [31:0] hit, irq_cause, base_pc, vec_pc;
  logic        take_irq;
  logic        exc_o_nxt, rv_o_nxt;
  logic [31:0] cause_o_nxt, pc_o_nxt, rpc_o_nxt;

  assign mip_pend = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};
  assign hit      = mip_pend & csr_mie;
  assign take_irq = commit_valid & csr_interrupt_en & (|hit);
  assign base_pc  = {csr_mtvec_base, 2'b00};

  always_comb begin
    irq_cause = 32'h8000_0007;
    if (hit[11])     irq_cause = 32'h8000_000B;
    else if (hit[3]) irq_cause = 32'h8000_0003;
  end

`ifdef TRAP_VECTORED_EN
  always_comb begin
    vec_pc = base_pc;
    if (csr_mtvec_mode == 2'd1 && is_irq)
      vec_pc = base_pc + {25'b0, cause_q[4:0], 2'b00};
  end
`else
  logic unused_mode;
  assign unused_mode = ^csr_mtvec_mode;
  assign vec_pc      = base_pc;
`endif

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state               <= IDLE;
      tgt_ret             <= 1'b0;
      is_irq              <= 1'b0;
      cause_q             <= '0;
      epc_q               <= '0;
      csr_exception       <= 1'b0;
      csr_exception_cause <= '0;
      csr_exception_pc    <= '0;
      redirect_valid      <= 1'b0;
      redirect_pc         <= '0;
    end else begin
      state               <= state_nxt;
      tgt_ret             <= tgt_ret_nxt;
      is_irq              <= is_irq_nxt;
      cause_q             <= cause_nxt;
      epc_q               <= epc_nxt;
      csr_exception       <= exc_o_nxt;
      csr_exception_cause <= cause_o_nxt;
      csr_exception_pc    <= pc_o_nxt;
      redirect_valid      <= rv_o_nxt;
      redirect_pc         <= rpc_o_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tgt_ret_nxt = tgt_ret;
    is_irq_nxt  = is_irq;
    cause_nxt   = cause_q;
    epc_nxt     = epc_q;
    unique case (state)
      IDLE: begin
        if (exc_valid) begin
          state_nxt   = FLUSH;
          tgt_ret_nxt = 1'b0;
          is_irq_nxt  = 1'b0;
          cause_nxt   = {27'b0, exc_code};
          epc_nxt     = exc_pc;
        end else if (take_irq) begin
          state_nxt   = FLUSH;
          tgt_ret_nxt = 1'b0;
          is_irq_nxt  = 1'b1;
          cause_nxt   = irq_cause;
          epc_nxt     = commit_pc;
        end else if (mret_valid) begin
          state_nxt   = FLUSH;
          tgt_ret_nxt = 1'b1;
        end
      end
      FLUSH: if (flush_ack) state_nxt = tgt_ret ? RET : TRAP;
      TRAP:  state_nxt = IDLE;
      RET:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are precomputed on the flush_ack cycle so they leave a register.
  always_comb begin
    exc_o_nxt   = 1'b0;
    rv_o_nxt    = 1'b0;
    cause_o_nxt = '0;
    pc_o_nxt    = '0;
    rpc_o_nxt   = '0;
    if (state == FLUSH && flush_ack) begin
      rv_o_nxt = 1'b1;
      if (tgt_ret) begin
        rpc_o_nxt = csr_mepc;
      end else begin
        exc_o_nxt   = 1'b1;
        cause_o_nxt = cause_q;
        pc_o_nxt    = epc_q;
        rpc_o_nxt   = vec_pc;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign flush_req = (state == FLUSH);

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl.
// Expected redirect targets depend on whether TRAP_VECTORED_EN is defined.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        nrst;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        mret_valid;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        irq_sw, irq_timer, irq_ext;
  logic        csr_interrupt_en;
  logic [31:0] csr_mie;
  logic [1:0]  csr_mtvec_mode;
  logic [29:0] csr_mtvec_base;
  logic [31:0] csr_mepc;
  logic        flush_req, flush_ack, busy;
  logic        csr_exception;
  logic [31:0] csr_exception_cause, csr_exception_pc;
  logic [31:0] mip_pend;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk(clk), .nrst(nrst),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .mret_valid(mret_valid),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext),
    .csr_interrupt_en(csr_interrupt_en), .csr_mie(csr_mie),
    .csr_mtvec_mode(csr_mtvec_mode), .csr_mtvec_base(csr_mtvec_base),
    .csr_mepc(csr_mepc),
    .flush_req(flush_req), .flush_ack(flush_ack), .busy(busy),
    .csr_exception(csr_exception),
    .csr_exception_cause(csr_exception_cause),
    .csr_exception_pc(csr_exception_pc),
    .mip_pend(mip_pend),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  typedef struct {
    string       name;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] epc_in;
    logic        mret;
    logic        cv;
    logic [31:0] cpc;
    logic [2:0]  irq;
    logic        ie;
    logic [31:0] mie;
    logic [1:0]  mode;
    logic [29:0] base;
    logic [31:0] mepc;
    int          ackdly;
    logic        taken;
    logic        xexc;
    logic [31:0] xcause;
    logic [31:0] xepc;
    logic [31:0] xrpc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    exc_valid = 0; exc_code = 0; exc_pc = 0; mret_valid = 0;
    irq_sw = 0; irq_timer = 0; irq_ext = 0;
  endtask

  function automatic vec_t mk(
    string nm, logic exc, logic [4:0] code, logic [31:0] epc_in,
    logic mret, logic cv, logic [31:0] cpc, logic [2:0] irq, logic ie,
    logic [31:0] mie, logic [1:0] mode, logic [29:0] base,
    logic [31:0] mepc, int ackdly, logic taken, logic xexc,
    logic [31:0] xcause, logic [31:0] xepc, logic [31:0] xrpc);
    vec_t v;
    v.name = nm; v.exc = exc; v.code = code; v.epc_in = epc_in;
    v.mret = mret; v.cv = cv; v.cpc = cpc; v.irq = irq; v.ie = ie;
    v.mie = mie; v.mode = mode; v.base = base; v.mepc = mepc;
    v.ackdly = ackdly; v.taken = taken; v.xexc = xexc;
    v.xcause = xcause; v.xepc = xepc; v.xrpc = xrpc;
    return v;
  endfunction

  // irq field order: {ext, timer, sw}
  task automatic run_vec(input vec_t v);
    exc_valid = v.exc; exc_code = v.code; exc_pc = v.epc_in;
    mret_valid = v.mret; commit_valid = v.cv; commit_pc = v.cpc;
    {irq_ext, irq_timer, irq_sw} = v.irq;
    csr_interrupt_en = v.ie; csr_mie = v.mie;
    csr_mtvec_mode = v.mode; csr_mtvec_base = v.base; csr_mepc = v.mepc;
    tick();
    idle_inputs();
    chk({v.name, ".busy"}, {31'b0, busy}, {31'b0, v.taken});
    if (!v.taken) begin
      tick();
      chk({v.name, ".busy2"}, {31'b0, busy}, 32'd0);
      return;
    end
    chk({v.name, ".flush_req"}, {31'b0, flush_req}, 32'd1);
    for (int i = 0; i < v.ackdly; i++) begin
      tick();
      chk({v.name, ".hold"}, {30'b0, flush_req, redirect_valid}, 32'd2);
    end
    flush_ack = 1;
    tick();
    flush_ack = 0;
    chk({v.name, ".rv"}, {31'b0, redirect_valid}, 32'd1);
    chk({v.name, ".rpc"}, redirect_pc, v.xrpc);
    chk({v.name, ".exc"}, {31'b0, csr_exception}, {31'b0, v.xexc});
    chk({v.name, ".cause"}, csr_exception_cause, v.xcause);
    chk({v.name, ".epc"}, csr_exception_pc, v.xepc);
    chk({v.name, ".freq"}, {31'b0, flush_req}, 32'd0);
    tick();
    chk({v.name, ".after"},
        {29'b0, busy, csr_exception, redirect_valid}, 32'd0);
    chk({v.name, ".after_rpc"}, redirect_pc, 32'd0);
  endtask

  localparam logic [31:0] C_SW = 32'h8000_0003;
  localparam logic [31:0] C_TM = 32'h8000_0007;
  localparam logic [31:0] C_EX = 32'h8000_000B;

  initial begin
    logic [31:0] v_ext, v_sw, v_wrap, v_tm2;
`ifdef TRAP_VECTORED_EN
    v_ext = 32'h802C; v_sw = 32'h800C; v_wrap = 32'h18;
`else
    v_ext = 32'h8000; v_sw = 32'h8000; v_wrap = 32'hFFFF_FFFC;
`endif
    v_tm2 = 32'h8000;

    vecs.push_back(mk("exc_timing", 1, 5'd2, 32'h100, 0, 0, 0, 3'b000, 0,
      0, 2'd0, 30'h2000, 0, 3, 1, 1, 32'h2, 32'h100, 32'h8000));
    vecs.push_back(mk("irq_prio", 0, 0, 0, 0, 1, 32'h204, 3'b110, 1,
      32'h880, 2'd1, 30'h2000, 0, 0, 1, 1, C_EX, 32'h204, v_ext));
    vecs.push_back(mk("gate_ie", 0, 0, 0, 0, 1, 32'h10, 3'b001, 0,
      32'h888, 2'd0, 30'h2000, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("gate_mie", 0, 0, 0, 0, 1, 32'h10, 3'b001, 1,
      32'h880, 2'd0, 30'h2000, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("gate_cv", 0, 0, 0, 0, 0, 32'h10, 3'b001, 1,
      32'h888, 2'd0, 30'h2000, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("exc_over_mret", 1, 5'd5, 32'h300, 1, 0, 0, 3'b000,
      0, 0, 2'd0, 30'h2000, 32'h1234, 1, 1, 1, 32'h5, 32'h300, 32'h8000));
    vecs.push_back(mk("mret", 0, 0, 0, 1, 0, 0, 3'b000, 0, 0, 2'd0,
      30'h2000, 32'h1234, 2, 1, 0, 0, 0, 32'h1234));
    vecs.push_back(mk("sw_over_tm", 0, 0, 0, 0, 1, 32'h500, 3'b011, 1,
      32'h88, 2'd1, 30'h2000, 0, 0, 1, 1, C_SW, 32'h500, v_sw));
    vecs.push_back(mk("tm_mode2", 0, 0, 0, 0, 1, 32'h600, 3'b010, 1,
      32'h80, 2'd2, 30'h2000, 0, 1, 1, 1, C_TM, 32'h600, v_tm2));
    vecs.push_back(mk("exc_mode1", 1, 5'd11, 32'h400, 0, 1, 32'h9, 3'b100,
      1, 32'h800, 2'd1, 30'h3FFF_FFFF, 0, 0, 1, 1, 32'hB, 32'h400,
      32'hFFFF_FFFC));
    vecs.push_back(mk("tm_wrap", 0, 0, 0, 0, 1, 32'h700, 3'b010, 1,
      32'h80, 2'd1, 30'h3FFF_FFFF, 0, 0, 1, 1, C_TM, 32'h700, v_wrap));
    vecs.push_back(mk("irq_over_mret", 0, 0, 0, 1, 1, 32'h800, 3'b001, 1,
      32'h8, 2'd0, 30'h40, 32'h1234, 0, 1, 1, C_SW, 32'h800, 32'h100));

    // reset state
    idle_inputs();
    commit_valid = 0; commit_pc = 0; csr_interrupt_en = 0; csr_mie = 0;
    csr_mtvec_mode = 0; csr_mtvec_base = 0; csr_mepc = 0; flush_ack = 0;
    nrst = 0;
    tick(); tick();
    chk("rst.ctl", {27'b0, flush_req, busy, csr_exception,
        redirect_valid, 1'b0}, 32'd0);
    chk("rst.cause", csr_exception_cause, 32'd0);
    chk("rst.epc", csr_exception_pc, 32'd0);
    chk("rst.rpc", redirect_pc, 32'd0);
    chk("rst.mip", mip_pend, 32'd0);
    nrst = 1;
    tick();

    // mip_pend is live and combinational
    irq_sw = 1; irq_timer = 1; irq_ext = 1;
    #1 chk("mip.all", mip_pend, 32'h888);
    irq_sw = 0; irq_ext = 0;
    #1 chk("mip.tm", mip_pend, 32'h80);
    irq_timer = 0;

    // flush_ack in IDLE is ignored
    flush_ack = 1;
    tick(); tick();
    chk("ack_idle", {30'b0, busy, redirect_valid}, 32'd0);
    flush_ack = 0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // events during FLUSH are ignored; latched cause survives
    csr_mtvec_base = 30'h2000; csr_mtvec_mode = 0;
    exc_valid = 1; exc_code = 5'd3; exc_pc = 32'hA0;
    tick();
    exc_code = 5'd7; exc_pc = 32'hB0; mret_valid = 1;
    tick();
    idle_inputs();
    flush_ack = 1;
    tick();
    flush_ack = 0;
    chk("ign.cause", csr_exception_cause, 32'h3);
    chk("ign.epc", csr_exception_pc, 32'hA0);
    tick();
    tick();
    chk("ign.idle", {31'b0, busy}, 32'd0);

    // reset during FLUSH aborts without a strobe
    exc_valid = 1; exc_code = 5'd4; exc_pc = 32'hC0;
    tick();
    idle_inputs();
    chk("mrst.flush", {31'b0, flush_req}, 32'd1);
    nrst = 0;
    flush_ack = 1;
    tick();
    nrst = 1;
    chk("mrst.idle", {29'b0, busy, csr_exception, redirect_valid}, 32'd0);
    tick();
    chk("mrst.nostrobe",
        {29'b0, busy, csr_exception, redirect_valid}, 32'd0);
    flush_ack = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
